// File: rtl/fifo_word32_pkg.sv
// Shared word-path defaults for the byte-to-word mux and the word FIFO behind it.
package fifo_word32_pkg;

  localparam int WORD_W        = 32;
  localparam int FIFO_DEPTH    = 4;
  localparam int FIFO_AF_LEVEL = 3;
  localparam int FIFO_AE_LEVEL = 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_mem_word32.sv
// FIFO storage: one write port, one registered read port; array itself is not reset.
module fifo_mem_word32 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read-before-write on a shared address: a pop from a full FIFO sees the old word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_word32.sv
// Word FIFO behind the 8-to-32 mux: pointers, occupancy, flags and sticky overflow.
module fifo_word32
  import fifo_word32_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int AF_LEVEL = FIFO_AF_LEVEL,
  parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
  input  logic                       clk_f,
  input  logic                       reset_L,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       valid_in,
  input  logic                       pop,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q;
  logic          ovf_q, ovf_d;
  logic          push_acc, pop_acc;
  fifo_flags_t   flags;

  // Flags come only from the registered count, never from this cycle's inputs.
  always_comb begin
    flags.full         = (count_q == DEPTH_C);
    flags.empty        = (count_q == '0);
    flags.almost_full  = (count_q >= AF_C);
    flags.almost_empty = (count_q <= AE_C);
  end

  assign pop_acc  = pop && !flags.empty;
  assign push_acc = valid_in && (!flags.full || pop_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (valid_in && !push_acc) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= pop_acc;
      ovf_q    <= ovf_d;
    end
  end

  fifo_mem_word32 #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_f),
    .rst_ni  (reset_L),
    .we_i    (push_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .re_i    (pop_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_out)
  );

  assign valid_out    = valid_q;
  assign overflow_err = ovf_q;
  assign count        = count_q;
  assign full         = flags.full;
  assign empty        = flags.empty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;

endmodule

// File: tb/tb_fifo_word32.sv
// Directed bench for fifo_word32: vector table plus wrap and mid-stream reset sequences.
module tb_fifo_word32;

  logic        clk_f = 1'b0;
  logic        reset_L;
  logic [31:0] data_in;
  logic        valid_in;
  logic        pop;
  logic [31:0] data_out;
  logic        valid_out;
  logic        full, empty, almost_full, almost_empty;
  logic [2:0]  count;
  logic        overflow_err;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_word32 dut (
    .clk_f        (clk_f),
    .reset_L      (reset_L),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow_err (overflow_err)
  );

  always #5 clk_f = ~clk_f;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        vi;
    logic        pp;
    logic [31:0] din;
    logic        vo;
    logic [31:0] dout;
    logic [2:0]  cnt;
    logic        f, e, af, ae, ov;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(logic vi, logic pp, logic [31:0] din, logic vo,
                              logic [31:0] dout, logic [2:0] cnt, logic f,
                              logic e, logic af, logic ae, logic ov);
    vec_t v;
    v.vi = vi; v.pp = pp; v.din = din; v.vo = vo; v.dout = dout; v.cnt = cnt;
    v.f = f; v.e = e; v.af = af; v.ae = ae; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " data_out"},     data_out,     32'h0);
    chk({tag, " valid_out"},    valid_out,    32'h0);
    chk({tag, " count"},        count,        32'h0);
    chk({tag, " empty"},        empty,        32'h1);
    chk({tag, " almost_empty"}, almost_empty, 32'h1);
    chk({tag, " full"},         full,         32'h0);
    chk({tag, " almost_full"},  almost_full,  32'h0);
    chk({tag, " overflow_err"}, overflow_err, 32'h0);
  endtask

  task automatic step(input logic vi, input logic pp, input logic [31:0] din);
    @(negedge clk_f);
    valid_in = vi;
    pop      = pp;
    data_in  = din;
    @(posedge clk_f);
    #1;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] exp_w;
    logic [31:0] nxt;

    reset_L  = 1'b0;
    valid_in = 1'b0;
    pop      = 1'b0;
    data_in  = '0;

    vt[0]  = mk(1, 0, 32'hA1B2C3D4, 0, 32'h00000000, 1, 0, 0, 0, 1, 0);
    vt[1]  = mk(0, 1, 32'h0,        1, 32'hA1B2C3D4, 0, 0, 1, 0, 1, 0);
    vt[2]  = mk(0, 0, 32'h0,        0, 32'hA1B2C3D4, 0, 0, 1, 0, 1, 0);
    vt[3]  = mk(1, 0, 32'h11111111, 0, 32'hA1B2C3D4, 1, 0, 0, 0, 1, 0);
    vt[4]  = mk(1, 0, 32'h22222222, 0, 32'hA1B2C3D4, 2, 0, 0, 0, 0, 0);
    vt[5]  = mk(1, 0, 32'h33333333, 0, 32'hA1B2C3D4, 3, 0, 0, 1, 0, 0);
    vt[6]  = mk(1, 0, 32'h44444444, 0, 32'hA1B2C3D4, 4, 1, 0, 1, 0, 0);
    vt[7]  = mk(1, 0, 32'h55555555, 0, 32'hA1B2C3D4, 4, 1, 0, 1, 0, 1);
    vt[8]  = mk(1, 1, 32'h66666666, 1, 32'h11111111, 4, 1, 0, 1, 0, 1);
    vt[9]  = mk(0, 1, 32'h0,        1, 32'h22222222, 3, 0, 0, 1, 0, 1);
    vt[10] = mk(0, 1, 32'h0,        1, 32'h33333333, 2, 0, 0, 0, 0, 1);
    vt[11] = mk(0, 1, 32'h0,        1, 32'h44444444, 1, 0, 0, 0, 1, 1);
    vt[12] = mk(0, 1, 32'h0,        1, 32'h66666666, 0, 0, 1, 0, 1, 1);
    vt[13] = mk(0, 1, 32'h0,        0, 32'h66666666, 0, 0, 1, 0, 1, 1);
    vt[14] = mk(1, 1, 32'h77777777, 0, 32'h66666666, 1, 0, 0, 0, 1, 1);
    vt[15] = mk(0, 1, 32'h0,        1, 32'h77777777, 0, 0, 1, 0, 1, 1);

    repeat (2) @(posedge clk_f);
    #1;
    chk_reset_state("reset");
    @(negedge clk_f);
    reset_L = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(vt[i].vi, vt[i].pp, vt[i].din);
      chk($sformatf("v%0d valid_out", i),    valid_out,    vt[i].vo);
      chk($sformatf("v%0d data_out", i),     data_out,     vt[i].dout);
      chk($sformatf("v%0d count", i),        count,        vt[i].cnt);
      chk($sformatf("v%0d full", i),         full,         vt[i].f);
      chk($sformatf("v%0d empty", i),        empty,        vt[i].e);
      chk($sformatf("v%0d almost_full", i),  almost_full,  vt[i].af);
      chk($sformatf("v%0d almost_empty", i), almost_empty, vt[i].ae);
      chk($sformatf("v%0d overflow_err", i), overflow_err, vt[i].ov);
    end

    // Wrap: two resident words, ten push+pop cycles, then drain.
    @(negedge clk_f);
    valid_in = 1'b0;
    pop      = 1'b0;
    reset_L  = 1'b0;
    @(negedge clk_f);
    reset_L  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      nxt = 32'hB0000000 + 32'(i);
      q.push_back(nxt);
      step(1'b1, 1'b0, nxt);
    end
    chk("wrap fill count", count, 32'd2);
    for (int i = 0; i < 10; i++) begin
      nxt   = 32'hB0000100 + 32'(i);
      exp_w = q.pop_front();
      q.push_back(nxt);
      step(1'b1, 1'b1, nxt);
      chk($sformatf("wrap%0d valid_out", i), valid_out, 32'h1);
      chk($sformatf("wrap%0d data_out", i),  data_out,  exp_w);
      chk($sformatf("wrap%0d count", i),     count,     32'd2);
    end
    for (int i = 0; i < 2; i++) begin
      exp_w = q.pop_front();
      step(1'b0, 1'b1, 32'h0);
      chk($sformatf("drain%0d data_out", i), data_out, exp_w);
      chk($sformatf("drain%0d valid_out", i), valid_out, 32'h1);
    end
    chk("drain empty", empty, 32'h1);
    chk("wrap overflow_err", overflow_err, 32'h0);

    // Mid-stream asynchronous reset, then behaviour from empty.
    step(1'b1, 1'b0, 32'hC0000001);
    step(1'b1, 1'b0, 32'hC0000002);
    step(1'b1, 1'b1, 32'hC0000003);
    chk("pre-reset valid_out", valid_out, 32'h1);
    chk("pre-reset data_out",  data_out,  32'hC0000001);
    #2;
    reset_L  = 1'b0;
    valid_in = 1'b0;
    pop      = 1'b0;
    #1;
    chk_reset_state("async");
    @(negedge clk_f);
    reset_L = 1'b1;
    step(1'b1, 1'b1, 32'hCAFEF00D);
    chk("post-reset valid_out", valid_out, 32'h0);
    chk("post-reset count",     count,     32'd1);
    step(1'b0, 1'b1, 32'h0);
    chk("post-reset pop valid", valid_out, 32'h1);
    chk("post-reset pop data",  data_out,  32'hCAFEF00D);
    chk("post-reset empty",     empty,     32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
